dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the pipeline's MEM stage (core port) and an external master (ext port: boot loader / debug / DMA).
- Single-cycle request/grant arbitration. Core has priority. Ext gets a starvation-bounded guaranteed slot.
- Sits between the pipeline MEM-stage registers and the Data_memory instance. Drives that instance's wr_en, rd_en, addr and wr_data pins, and takes its rdata.
- Read data returns registered, one cycle after grant.

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core has priority, ext wins after MAX_WAIT denials.
// Optional ext bus locking is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   input  logic              ext_lock,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              mem_wr_en,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {ARB, EXT_LOCK} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_EXT} owner_t;

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   state_t            state_reg, state_next;
   owner_t            rsp_owner_reg, rsp_owner_next;
   logic [3:0]        wait_cnt_reg, wait_cnt_next;
   logic [DATA_W-1:0] core_rdata_reg, ext_rdata_reg;
   logic              force_ext;

`ifndef DMEM_ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = ext_lock;
`endif

   // Grants are suppressed during reset so no memory strobe leaks out while rst is high.
   always_comb begin
      force_ext = ext_req & ((wait_cnt_reg == WAIT_LIMIT) | (state_reg == EXT_LOCK));
      core_gnt  = ~rst & core_req & ~force_ext;
      ext_gnt   = ~rst & ext_req & ~core_gnt;
   end

   always_comb begin
      mem_wr_en   = 1'b0;
      mem_rd_en   = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      if (core_gnt) begin
         mem_wr_en   = core_we;
         mem_rd_en   = ~core_we;
         mem_addr    = core_addr;
         mem_wr_data = core_wdata;
      end else if (ext_gnt) begin
         mem_wr_en   = ext_we;
         mem_rd_en   = ~ext_we;
         mem_addr    = ext_addr;
         mem_wr_data = ext_wdata;
      end
   end

   always_comb begin
      wait_cnt_next = 4'd0;
      if (ext_req & ~ext_gnt)
         wait_cnt_next = (wait_cnt_reg == WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt_reg + 4'd1;

      rsp_owner_next = OWN_NONE;
      if (core_gnt & ~core_we)
         rsp_owner_next = OWN_CORE;
      else if (ext_gnt & ~ext_we)
         rsp_owner_next = OWN_EXT;

      state_next = state_reg;
`ifdef DMEM_ARB_LOCK_EN
      case (state_reg)
         ARB:      if (ext_gnt & ext_lock) state_next = EXT_LOCK;
         EXT_LOCK: if (~ext_lock | ~ext_req) state_next = ARB;
         default:  state_next = ARB;
      endcase
`else
      state_next = ARB;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ARB;
         rsp_owner_reg  <= OWN_NONE;
         wait_cnt_reg   <= 4'd0;
         core_rdata_reg <= '0;
         ext_rdata_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         rsp_owner_reg <= rsp_owner_next;
         wait_cnt_reg  <= wait_cnt_next;
         // Only the port that owns the read captures; the other keeps its last data.
         if (rsp_owner_next == OWN_CORE) core_rdata_reg <= mem_rdata;
         if (rsp_owner_next == OWN_EXT)  ext_rdata_reg  <= mem_rdata;
      end
   end

   assign core_rvalid = (rsp_owner_reg == OWN_CORE);
   assign ext_rvalid  = (rsp_owner_reg == OWN_EXT);
   assign core_rdata  = core_rdata_reg;
   assign ext_rdata   = ext_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected grant/rvalid events, a negedge monitor pops and compares.
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          preload = 1'b1;
   logic          core_req = 0, core_we = 0, ext_req = 0, ext_we = 0, ext_lock = 0;
   logic [AW-1:0] core_addr = '0, ext_addr = '0;
   logic [DW-1:0] core_wdata = '0, ext_wdata = '0;
   logic          core_gnt, core_rvalid, ext_gnt, ext_rvalid;
   logic [DW-1:0] core_rdata, ext_rdata;
   logic          mem_wr_en, mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wr_data, mem_rdata;
   logic [DW-1:0] mem [0:255];

   int compared = 0;
   int mismatched = 0;

   typedef struct packed {
      logic [1:0]  kind;   // 0 core_gnt, 1 ext_gnt, 2 core_rvalid, 3 ext_rvalid
      logic        we;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] data;
   } evt_t;

   evt_t exp_q[$];

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[7:0]];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem[8'h10] <= 32'hDEADBEEF;
         mem[8'h40] <= 32'h0000_1234;
      end else if (mem_wr_en) begin
         mem[mem_addr[7:0]] <= mem_wr_data;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end else begin
         $display("check %s = %h", name, act);
      end
   endtask

   task automatic check_evt(input evt_t got);
      evt_t want;
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $display("FAIL unexpected_event: got kind=%0d we=%0b rd=%0b addr=%h data=%h, required none",
                  got.kind, got.we, got.rd, got.addr, got.data);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            mismatched++;
            $display("FAIL event: got kind=%0d we=%0b rd=%0b addr=%h data=%h, required kind=%0d we=%0b rd=%0b addr=%h data=%h",
                     got.kind, got.we, got.rd, got.addr, got.data,
                     want.kind, want.we, want.rd, want.addr, want.data);
         end else begin
            $display("event kind=%0d we=%0b addr=%h data=%h", got.kind, got.we, got.addr, got.data);
         end
      end
   endtask

   task automatic push_gnt(input logic is_ext, input logic we, input logic [31:0] addr, input logic [31:0] data);
      exp_q.push_back('{kind: {1'b0, is_ext}, we: we, rd: ~we, addr: addr, data: data});
   endtask

   task automatic push_rv(input logic is_ext, input logic [31:0] data);
      exp_q.push_back('{kind: {1'b1, is_ext}, we: 1'b0, rd: 1'b0, addr: 32'h0, data: data});
   endtask

   // Drive one cycle of requests, then return 1 time unit after the closing edge.
   task automatic cyc(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                      input logic el);
      core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
      ext_req = er;  ext_we = ew;  ext_addr = ea;  ext_wdata = ed; ext_lock = el;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every grant and rvalid seen away from the edge is matched against the queue.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && !preload) begin
            if (core_rvalid) check_evt('{kind: 2'd2, we: 1'b0, rd: 1'b0, addr: 32'h0, data: core_rdata});
            if (ext_rvalid)  check_evt('{kind: 2'd3, we: 1'b0, rd: 1'b0, addr: 32'h0, data: ext_rdata});
            if (core_gnt)    check_evt('{kind: 2'd0, we: mem_wr_en, rd: mem_rd_en, addr: mem_addr, data: mem_wr_data});
            if (ext_gnt)     check_evt('{kind: 2'd1, we: mem_wr_en, rd: mem_rd_en, addr: mem_addr, data: mem_wr_data});
            if (!core_gnt && !ext_gnt && (mem_wr_en || mem_rd_en || mem_addr != 0 || mem_wr_data != 0)) begin
               compared++;
               mismatched++;
               $display("FAIL idle_mem_drive: got wr=%0b rd=%0b addr=%h wdata=%h, required all 0",
                        mem_wr_en, mem_rd_en, mem_addr, mem_wr_data);
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_core_rvalid", {31'b0, core_rvalid}, 0);
      check("reset_ext_rvalid", {31'b0, ext_rvalid}, 0);
      check("reset_core_rdata", core_rdata, 0);
      check("reset_ext_rdata", ext_rdata, 0);
      check("reset_grants", {30'b0, core_gnt, ext_gnt}, 0);
      check("reset_mem_strobes", {30'b0, mem_wr_en, mem_rd_en}, 0);
      check("reset_wait_cnt", {28'b0, dut.wait_cnt_reg}, 0);
      preload = 0;
      rst = 0;

      // Core read alone
      push_gnt(0, 0, 32'h10, 0);
      cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
      push_rv(0, 32'hDEADBEEF);
      idle();
      idle();
      check("core_rdata_hold", core_rdata, 32'hDEADBEEF);

      // Contention: ext forced in on the fifth cycle
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) push_rv(0, 32'hDEADBEEF);
         push_gnt(0, 0, 32'h10, 0);
         cyc(1, 0, 32'h10, 0, 1, 1, 32'h20, 32'h55, 0);
         check($sformatf("wait_cnt_%0d", i), {28'b0, dut.wait_cnt_reg}, i);
      end
      push_rv(0, 32'hDEADBEEF);
      push_gnt(1, 1, 32'h20, 32'h55);
      cyc(1, 0, 32'h10, 0, 1, 1, 32'h20, 32'h55, 0);
      check("wait_cnt_after_ext", {28'b0, dut.wait_cnt_reg}, 0);
      push_gnt(0, 0, 32'h10, 0);
      cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
      push_rv(0, 32'hDEADBEEF);
      idle();

      // Ext read alone
      push_gnt(1, 0, 32'h40, 0);
      cyc(0, 0, 0, 0, 1, 0, 32'h40, 0, 0);
      push_rv(1, 32'h1234);
      idle();
      check("core_rdata_untouched", core_rdata, 32'hDEADBEEF);

      // Abandoned ext request
      push_gnt(0, 0, 32'h10, 0);
      cyc(1, 0, 32'h10, 0, 1, 1, 32'h30, 32'h77, 0);
      push_rv(0, 32'hDEADBEEF);
      push_gnt(0, 0, 32'h10, 0);
      cyc(1, 0, 32'h10, 0, 1, 1, 32'h30, 32'h77, 0);
      check("abandon_wait_2", {28'b0, dut.wait_cnt_reg}, 2);
      push_rv(0, 32'hDEADBEEF);
      push_gnt(0, 0, 32'h10, 0);
      cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
      check("abandon_wait_0", {28'b0, dut.wait_cnt_reg}, 0);
      push_rv(0, 32'hDEADBEEF);
      idle();
      check("abandon_no_write", mem[8'h30], 0);

      // Reset in the cycle after a granted read
      push_gnt(0, 0, 32'h40, 0);
      cyc(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
      rst = 1;
      #1;
      check("midrst_core_rvalid", {31'b0, core_rvalid}, 0);
      check("midrst_core_rdata", core_rdata, 0);
      check("midrst_core_gnt", {31'b0, core_gnt}, 0);
      check("midrst_mem", {mem_wr_en, mem_rd_en, mem_addr[29:0]}, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 0;
      push_gnt(0, 0, 32'h40, 0);
      cyc(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
      push_rv(0, 32'h1234);
      idle();

      // Three-beat locked ext write against core traffic
`ifdef DMEM_ARB_LOCK_EN
      push_gnt(1, 1, 32'h0, 32'hA0);
      cyc(0, 0, 0, 0, 1, 1, 32'h0, 32'hA0, 1);
      push_gnt(1, 1, 32'h4, 32'hA1);
      cyc(1, 0, 32'h10, 0, 1, 1, 32'h4, 32'hA1, 1);
      push_gnt(1, 1, 32'h8, 32'hA2);
      cyc(1, 0, 32'h10, 0, 1, 1, 32'h8, 32'hA2, 1);
      push_gnt(0, 0, 32'h10, 0);
      cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
      push_rv(0, 32'hDEADBEEF);
      idle();
`else
      push_gnt(1, 1, 32'h0, 32'hA0);
      cyc(0, 0, 0, 0, 1, 1, 32'h0, 32'hA0, 1);
      push_gnt(0, 0, 32'h10, 0);
      cyc(1, 0, 32'h10, 0, 1, 1, 32'h4, 32'hA1, 1);
      push_rv(0, 32'hDEADBEEF);
      push_gnt(0, 0, 32'h10, 0);
      cyc(1, 0, 32'h10, 0, 1, 1, 32'h4, 32'hA1, 1);
      push_rv(0, 32'hDEADBEEF);
      push_gnt(1, 1, 32'h4, 32'hA1);
      cyc(0, 0, 0, 0, 1, 1, 32'h4, 32'hA1, 1);
      push_gnt(1, 1, 32'h8, 32'hA2);
      cyc(0, 0, 0, 0, 1, 1, 32'h8, 32'hA2, 1);
      idle();
`endif

      // Read back committed writes, back-to-back and mixed ports
      push_gnt(0, 0, 32'h4, 0);
      cyc(1, 0, 32'h4, 0, 0, 0, 0, 0, 0);
      push_rv(0, 32'hA1);
      push_gnt(0, 0, 32'h20, 0);
      cyc(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
      push_rv(0, 32'h55);
      push_gnt(1, 0, 32'h8, 0);
      cyc(0, 0, 0, 0, 1, 0, 32'h8, 0, 0);
      push_rv(1, 32'hA2);
      idle();
      idle();
      check("ext_rdata_hold", ext_rdata, 32'hA2);
      check("mem_word0", mem[8'h00], 32'hA0);

      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL pending_events: got %0d left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
